// File: rtl/sram_stream_loader.sv
// Stream-to-SRAM DMA stage: loads AXI4-Stream words into feature/kernel SRAM
// and drains feature SRAM back out through a 4-deep credit-managed output FIFO.
module sram_stream_loader #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FRAM_BYTE_AW = 14,
  parameter int unsigned KRAM_BYTE_AW = 14,
  parameter int unsigned LEN_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hold,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic                    cmd_target,
  input  logic [31:0]             cmd_baseaddr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [FRAM_BYTE_AW-1:0] fram_addr_byteidx,
  output logic [DATA_WIDTH-1:0]   fram_wdata,
  output logic                    fram_we,
  output logic                    fram_en,
  input  logic [DATA_WIDTH-1:0]   fram_rdata,
  output logic [KRAM_BYTE_AW-1:0] kram_addr_byteidx,
  output logic [DATA_WIDTH-1:0]   kram_wdata,
  output logic                    kram_we,
  output logic                    kram_en,
  input  logic [DATA_WIDTH-1:0]   kram_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int unsigned ADDR_W     = (FRAM_BYTE_AW > KRAM_BYTE_AW) ? FRAM_BYTE_AW : KRAM_BYTE_AW;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned SUM_W      = 4;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  state_t                state;
  logic [ADDR_W-1:0]     addr;
  logic                  target;
  logic [LEN_WIDTH-1:0]  issue_rem;
  logic [LEN_WIDTH-1:0]  out_rem;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  rd_vld;

  logic                  accept;
  logic                  beat;
  logic                  pop;
  logic                  push;
  logic                  rd_issue;
  logic [SUM_W-1:0]      credit_used;
  logic [CNT_W-1:0]      cnt_n;
  logic [PTR_W-1:0]      rd_ptr_n;
  logic [LEN_WIDTH-1:0]  out_rem_n;
  logic [DATA_WIDTH-1:0] head_data_n;
  logic [ADDR_W-1:0]     base_aligned;
  logic                  unused_ok;

  // Handshakes, read credit and next FIFO head (bypass when the pushed word becomes head)
  always_comb begin
    accept       = cmd_valid & cmd_ready;
    beat         = s_axis_tvalid & s_axis_tready;
    pop          = m_axis_tvalid & m_axis_tready;
    push         = rd_vld;
    credit_used  = SUM_W'(fifo_cnt) + SUM_W'(fram_en & ~fram_we) + SUM_W'(rd_vld);
    rd_issue     = (state == S_DRAIN) && (issue_rem != '0) && (credit_used < SUM_W'(FIFO_DEPTH));
    cnt_n        = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_n     = rd_ptr + PTR_W'(pop);
    out_rem_n    = out_rem - LEN_WIDTH'(pop);
    head_data_n  = (push && (fifo_cnt == CNT_W'(pop))) ? fram_rdata : fifo_mem[rd_ptr_n];
    base_aligned = {cmd_baseaddr[ADDR_W-1:2], 2'b00};
    unused_ok    = ^{kram_rdata, cmd_baseaddr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      addr              <= '0;
      target            <= 1'b0;
      issue_rem         <= '0;
      out_rem           <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_cnt          <= '0;
      rd_vld            <= 1'b0;
      cmd_ready         <= 1'b0;
      s_axis_tready     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      fram_addr_byteidx <= '0;
      fram_wdata        <= '0;
      fram_we           <= 1'b0;
      fram_en           <= 1'b0;
      kram_addr_byteidx <= '0;
      kram_wdata        <= '0;
      kram_we           <= 1'b0;
      kram_en           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      done      <= 1'b0;
      cmd_ready <= 1'b0;
      fram_en   <= 1'b0;
      fram_we   <= 1'b0;
      kram_en   <= 1'b0;
      kram_we   <= 1'b0;
      rd_vld    <= fram_en & ~fram_we;

      // Output FIFO: BRAM read data lands one cycle after the read strobe
      if (push) begin
        fifo_mem[wr_ptr] <= fram_rdata;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      rd_ptr        <= rd_ptr_n;
      fifo_cnt      <= cnt_n;
      out_rem       <= out_rem_n;
      m_axis_tvalid <= (cnt_n != '0);
      m_axis_tlast  <= (cnt_n != '0) && (out_rem_n == LEN_WIDTH'(1));
      if (cnt_n != '0) m_axis_tdata <= head_data_n;

      case (state)
        S_IDLE: begin
          cmd_ready <= ~hold;
          busy      <= 1'b0;
          if (accept) begin
            err <= 1'b0;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else if (cmd_dir) begin
              // First read goes out with the accept so data is ready two cycles later
              state             <= S_DRAIN;
              cmd_ready         <= 1'b0;
              busy              <= 1'b1;
              fram_en           <= 1'b1;
              fram_addr_byteidx <= base_aligned[FRAM_BYTE_AW-1:0];
              addr              <= base_aligned + ADDR_W'(4);
              issue_rem         <= cmd_len - LEN_WIDTH'(1);
              out_rem           <= cmd_len;
            end else begin
              state         <= S_LOAD;
              cmd_ready     <= 1'b0;
              busy          <= 1'b1;
              s_axis_tready <= 1'b1;
              target        <= cmd_target;
              addr          <= base_aligned;
              issue_rem     <= cmd_len;
            end
          end
        end
        S_LOAD: begin
          if (beat) begin
            if (target) begin
              kram_en           <= 1'b1;
              kram_we           <= 1'b1;
              kram_addr_byteidx <= addr[KRAM_BYTE_AW-1:0];
              kram_wdata        <= s_axis_tdata;
            end else begin
              fram_en           <= 1'b1;
              fram_we           <= 1'b1;
              fram_addr_byteidx <= addr[FRAM_BYTE_AW-1:0];
              fram_wdata        <= s_axis_tdata;
            end
            if ((issue_rem == LEN_WIDTH'(1)) ? !s_axis_tlast : s_axis_tlast) err <= 1'b1;
            addr          <= addr + ADDR_W'(4);
            issue_rem     <= issue_rem - LEN_WIDTH'(1);
            s_axis_tready <= (issue_rem != LEN_WIDTH'(1));
          end else if (issue_rem == '0) begin
            state     <= S_IDLE;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= ~hold;
          end
        end
        S_DRAIN: begin
          if (rd_issue) begin
            fram_en           <= 1'b1;
            fram_addr_byteidx <= addr[FRAM_BYTE_AW-1:0];
            addr              <= addr + ADDR_W'(4);
            issue_rem         <= issue_rem - LEN_WIDTH'(1);
          end
          if (pop && (out_rem == LEN_WIDTH'(1))) begin
            state     <= S_IDLE;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= ~hold;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_stream_loader.sv
// Randomized self-checking bench for sram_stream_loader: a word-array model of
// feature SRAM predicts every write address/data and every drained beat.
module tb_sram_stream_loader;
  localparam int unsigned DW  = 32;
  localparam int unsigned FAW = 14;
  localparam int unsigned KAW = 14;
  localparam int unsigned LW  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           hold = 1'b0;
  logic           cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0, cmd_target = 1'b0;
  logic [31:0]    cmd_baseaddr = '0;
  logic [LW-1:0]  cmd_len = '0;
  logic [DW-1:0]  s_axis_tdata = '0;
  logic           s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  logic [FAW-1:0] fram_addr_byteidx;
  logic [DW-1:0]  fram_wdata, fram_rdata;
  logic           fram_we, fram_en;
  logic [KAW-1:0] kram_addr_byteidx;
  logic [DW-1:0]  kram_wdata;
  logic [DW-1:0]  kram_rdata = '0;
  logic           kram_we, kram_en;
  logic           busy, done, err;

  logic [DW-1:0]  fmem  [4096];
  logic [DW-1:0]  exp_f [4096];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             cyc = 0;

  sram_stream_loader #(.DATA_WIDTH(DW), .FRAM_BYTE_AW(FAW), .KRAM_BYTE_AW(KAW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_target(cmd_target),
    .cmd_baseaddr(cmd_baseaddr), .cmd_len(cmd_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .fram_addr_byteidx(fram_addr_byteidx), .fram_wdata(fram_wdata), .fram_we(fram_we),
    .fram_en(fram_en), .fram_rdata(fram_rdata),
    .kram_addr_byteidx(kram_addr_byteidx), .kram_wdata(kram_wdata), .kram_we(kram_we),
    .kram_en(kram_en), .kram_rdata(kram_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Feature BRAM with one-cycle read latency
  always @(posedge clk) begin
    if (fram_en) begin
      if (fram_we) fmem[fram_addr_byteidx[FAW-1:2]] <= fram_wdata;
      else         fram_rdata <= fmem[fram_addr_byteidx[FAW-1:2]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic dir, input logic tgt, input logic [31:0] base,
                           input logic [LW-1:0] len, output int t_acc);
    int guard = 0;
    cmd_dir = dir; cmd_target = tgt; cmd_baseaddr = base; cmd_len = len; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 50) begin step(); guard++; end
    if (guard >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, guard);
    end
    step();
    cmd_valid = 1'b0;
    t_acc = cyc - 1;
  endtask

  task automatic do_load(input logic tgt, input logic [31:0] base, input int len, input int last_idx,
                         input int extra, input bit rnd, input logic [DW-1:0] dbase, input string nm);
    logic [DW-1:0]  data [$];
    int             beat_cyc [$];
    int             wr_cyc [$];
    logic [FAW-1:0] wr_addr [$];
    logic [DW-1:0]  wr_data [$];
    int             t, idx, other_en, done_cnt, done_cyc;
    bit             bt;
    logic           exp_err;
    logic [31:0]    full;
    idx = 0; other_en = 0; done_cnt = 0; done_cyc = -1;
    for (int i = 0; i < len + extra; i++) data.push_back(rnd ? DW'($urandom) : dbase + DW'(i));
    issue_cmd(1'b0, tgt, base, LW'(len), t);
    for (int c = 0; c < len * 6 + 40; c++) begin
      if ((tgt ? kram_en : fram_en) === 1'b1 && (tgt ? kram_we : fram_we) === 1'b1) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(tgt ? kram_addr_byteidx : fram_addr_byteidx);
        wr_data.push_back(tgt ? kram_wdata : fram_wdata);
      end
      if ((tgt ? fram_en : kram_en) === 1'b1) other_en++;
      if (done === 1'b1) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      s_axis_tvalid = (idx < len + extra) && ($urandom_range(0, 3) != 0);
      s_axis_tdata  = (idx < len + extra) ? data[idx] : '0;
      s_axis_tlast  = (idx == last_idx);
      bt = s_axis_tvalid && (s_axis_tready === 1'b1);
      if (bt) beat_cyc.push_back(cyc);
      step();
      if (bt) idx++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    exp_err = (last_idx != len - 1);
    n_cmp++; if (idx != len) begin n_bad++; $display("FAIL %s beats_consumed: got %0d, required %0d", nm, idx, len); end
    n_cmp++; if (wr_cyc.size() != len) begin n_bad++; $display("FAIL %s write_count: got %0d, required %0d", nm, wr_cyc.size(), len); end
    for (int i = 0; i < wr_cyc.size() && i < len; i++) begin
      full = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      n_cmp++;
      if (wr_addr[i] !== full[FAW-1:0] || wr_data[i] !== data[i] ||
          (i < beat_cyc.size() && wr_cyc[i] != beat_cyc[i] + 1)) begin
        n_bad++;
        $display("FAIL %s write[%0d]: addr %h data %h, required addr %h data %h (write strobe one cycle after beat)",
                 nm, i, wr_addr[i], wr_data[i], full[FAW-1:0], data[i]);
      end
    end
    n_cmp++; if (other_en != 0) begin n_bad++; $display("FAIL %s other_port_en: %0d strobes, required 0", nm, other_en); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL %s done_count: got %0d, required 1", nm, done_cnt); end
    if (wr_cyc.size() > 0) begin
      n_cmp++;
      if (done_cyc != wr_cyc[wr_cyc.size() - 1] + 1) begin
        n_bad++; $display("FAIL %s done_timing: done at %0d, required %0d", nm, done_cyc, wr_cyc[wr_cyc.size() - 1] + 1);
      end
    end
    n_cmp++; if (err !== exp_err || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s err_after_done: err=%b busy=%b, required err=%b busy=0", nm, err, busy, exp_err);
    end
    if (!tgt) for (int i = 0; i < len; i++) begin
      full = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_f[full[FAW-1:2]] = data[i];
    end
  endtask

  task automatic do_drain(input logic [31:0] base, input int len, input int pct,
                          input bit full_rate, input bit hold_mid, input string nm);
    int            t, k, issued, first_v, last_hs, done_cyc, done_cnt, bad_we, over, stall_bad;
    logic          prev_stall, prev_last;
    logic [DW-1:0] prev_data, exp_d;
    logic [31:0]   full;
    k = 0; issued = 0; first_v = -1; last_hs = -1; done_cyc = -1; done_cnt = 0;
    bad_we = 0; over = 0; stall_bad = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    m_axis_tready = 1'b0;
    issue_cmd(1'b1, 1'b0, base, LW'(len), t);
    n_cmp++; if (fram_en !== 1'b1) begin n_bad++; $display("FAIL %s first_read_at_T+1: fram_en=%b, required 1", nm, fram_en); end
    for (int c = 0; c < len * 8 + 60; c++) begin
      if (hold_mid && c == 5) hold = 1'b1;
      if (fram_en === 1'b1) begin if (fram_we !== 1'b0) bad_we++; else issued++; end
      if (issued - k > 4) over++;
      if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last)) stall_bad++;
      if (m_axis_tvalid === 1'b1 && first_v < 0) first_v = cyc;
      if (done === 1'b1) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      m_axis_tready = full_rate || (int'($urandom_range(0, 99)) < pct);
      if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
        full  = (base & 32'hFFFF_FFFC) + 32'(4 * k);
        exp_d = exp_f[full[FAW-1:2]];
        n_cmp++;
        if (m_axis_tdata !== exp_d || m_axis_tlast !== 1'(k == len - 1)) begin
          n_bad++;
          $display("FAIL %s beat[%0d]: data %h last %b, required data %h last %b", nm, k, m_axis_tdata, m_axis_tlast, exp_d, k == len - 1);
        end
        last_hs = cyc; k++;
      end
      prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      step();
    end
    m_axis_tready = 1'b0; hold = 1'b0;
    n_cmp++; if (k != len) begin n_bad++; $display("FAIL %s beat_count: got %0d, required %0d", nm, k, len); end
    n_cmp++; if (issued != len || bad_we != 0) begin n_bad++; $display("FAIL %s reads: issued %0d writes %0d, required %0d reads 0 writes", nm, issued, bad_we, len); end
    n_cmp++; if (first_v != t + 3) begin n_bad++; $display("FAIL %s first_tvalid: cycle %0d, required %0d", nm, first_v, t + 3); end
    n_cmp++; if (done_cnt != 1 || done_cyc != last_hs + 1) begin
      n_bad++; $display("FAIL %s done: count %0d at %0d, required 1 at %0d", nm, done_cnt, done_cyc, last_hs + 1);
    end
    n_cmp++; if (over != 0 || stall_bad != 0) begin
      n_bad++; $display("FAIL %s credit_stability: %0d over-credit, %0d unstable stalls, required 0/0", nm, over, stall_bad);
    end
    if (full_rate) begin
      n_cmp++; if (last_hs != t + 2 + len) begin n_bad++; $display("FAIL %s throughput: last beat %0d, required %0d", nm, last_hs, t + 2 + len); end
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_cmp++;
    if ({cmd_ready, s_axis_tready, m_axis_tvalid, fram_en, kram_en, busy, done, err} !== 8'h00) begin
      n_bad++; $display("FAIL reset_outputs: %b, required 00000000", {cmd_ready, s_axis_tready, m_axis_tvalid, fram_en, kram_en, busy, done, err});
    end
    rst_n = 1'b1;
    step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: %b, required 1", cmd_ready); end
  endtask

  task automatic test_len0_err_clear();
    int t;
    issue_cmd(1'b0, 1'b0, 32'h80, '0, t);
    n_cmp++;
    if ({done, err, busy, s_axis_tready, fram_en, kram_en, m_axis_tvalid} !== 7'b1000000) begin
      n_bad++; $display("FAIL len0_accept: done/err/busy/tready/fen/ken/tvalid=%b, required 1000000",
                        {done, err, busy, s_axis_tready, fram_en, kram_en, m_axis_tvalid});
    end
    step();
    n_cmp++; if (done !== 1'b0 || fram_en !== 1'b0 || kram_en !== 1'b0) begin
      n_bad++; $display("FAIL len0_single_pulse: done=%b fen=%b ken=%b, required 0/0/0", done, fram_en, kram_en);
    end
  endtask

  task automatic test_hold();
    int t, h, leak;
    leak = 0;
    hold = 1'b1;
    repeat (2) step();
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL hold_cmd_ready: %b, required 0", cmd_ready); end
    cmd_dir = 1'b0; cmd_len = '0; cmd_valid = 1'b1;
    repeat (4) begin step(); if (done !== 1'b0 || cmd_ready !== 1'b0) leak++; end
    n_cmp++; if (leak != 0) begin n_bad++; $display("FAIL hold_blocks_accept: %0d cycles with accept, required 0", leak); end
    hold = 1'b0; h = cyc;
    issue_cmd(1'b0, 1'b0, 32'h0, '0, t);
    n_cmp++; if (t != h + 1 || done !== 1'b1) begin
      n_bad++; $display("FAIL hold_release_accept: accepted %0d done=%b, required %0d done=1", t, done, h + 1);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] b;
    int          l;
    for (int r = 0; r < 3; r++) begin
      b = 32'($urandom_range(0, 32'h3000)) & 32'hFFFF_FFFC;
      l = int'($urandom_range(1, 12));
      do_load(1'b0, b, l, l - 1, 1, 1'b1, '0, "b2b_load");
      do_drain(b, l, 70, 1'b0, 1'b0, "b2b_drain");
    end
  endtask

  task automatic test_reset_mid_drain();
    int t;
    m_axis_tready = 1'b1;
    issue_cmd(1'b1, 1'b0, 32'h400, LW'(20), t);
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, fram_en, fram_we, fram_addr_byteidx,
         fram_wdata, kram_en, kram_we, kram_addr_byteidx, kram_wdata, busy, done, err} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: tvalid=%b tdata=%h fen=%b faddr=%h busy=%b, required all zero",
                        m_axis_tvalid, m_axis_tdata, fram_en, fram_addr_byteidx, busy);
    end
    m_axis_tready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: ready=%b busy=%b tvalid=%b, required 1/0/0", cmd_ready, busy, m_axis_tvalid);
    end
    do_load(1'b0, 32'h600, 2, 1, 0, 1'b1, '0, "post_reset_load");
    do_drain(32'h600, 2, 100, 1'b1, 1'b0, "post_reset_drain");
  endtask

  initial begin
    test_reset();
    do_load(1'b0, 32'h40, 8, 7, 2, 1'b0, 32'h100, "load_fram");
    do_load(1'b1, 32'h13, 4, 1, 0, 1'b1, '0, "load_kram_err");
    test_len0_err_clear();
    test_hold();
    do_load(1'b0, 32'h400, 24, 23, 0, 1'b1, '0, "load_block");
    do_drain(32'h400, 16, 100, 1'b1, 1'b1, "drain_full_rate");
    do_drain(32'h404, 10, 50, 1'b0, 1'b0, "drain_backpressure");
    do_drain(32'h40, 8, 100, 1'b1, 1'b0, "drain_fixed");
    do_load(1'b0, 32'h3FF8, 3, 2, 0, 1'b1, '0, "load_wrap");
    do_drain(32'h3FF8, 3, 60, 1'b0, 1'b0, "drain_wrap");
    test_back_to_back();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
